// File: rtl/fifo_sync_prog.sv
// Purpose: single-clock FIFO with MSB-toggle pointers, occupancy count, programmable almost flags and sticky error flags.
// Latency: standard mode rd_data registered one cycle after an accepted rd_en; FWFT mode (FIFO_SYNC_PROG_FWFT_EN) shows the head combinationally.
// Backpressure: writes while full and reads while empty are dropped and latch overflow/underflow until rst or clr_err.
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  // Derived from ADDR_WIDTH; leave at its default.
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  // Thresholds narrowed to the count width so compares stay width-matched.
  localparam logic [ADDR_WIDTH:0] AF_T    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_T    = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status is purely a function of the pointers; the extra MSB separates full from empty.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign data_count   = wr_ptr - rd_ptr;
  assign almost_full  = (data_count >= AF_T);
  assign almost_empty = (data_count <= AE_T);

  // Acceptance uses the pre-edge flags only, so a full FIFO can still be read while a write is dropped.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Storage write; contents are intentionally not reset, but the reset cycle writes nothing.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Pointer advance; natural wrap at 2^(ADDR_WIDTH+1) toggles the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

`ifdef FIFO_SYNC_PROG_FWFT_EN
  // Head word falls through; value is meaningless while empty.
  assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];
`else
  // Registered read port; holds its last value when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_acc) begin
      rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end
`endif

  // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)      overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (rd_en && empty)     underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Purpose: directed self-checking bench for fifo_sync_prog (DEPTH 8, AF 7, AE 1).
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: exercises overflow/underflow, wrap with simultaneous traffic, and mid-run reset.
module tb_fifo_sync_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] data_count;
  logic       overflow;
  logic       underflow;
  logic       clr_err = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  fifo_sync_prog #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read; the caller may hold wr_en/wr_data for a simultaneous write.
  task automatic do_read(input string tag, input logic [7:0] exp);
`ifdef FIFO_SYNC_PROG_FWFT_EN
    chk(tag, rd_data, exp);
`endif
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
`ifndef FIFO_SYNC_PROG_FWFT_EN
    chk(tag, rd_data, exp);
`endif
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", data_count, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
`ifndef FIFO_SYNC_PROG_FWFT_EN
    chk("rst_rdata", rd_data, 0);
`endif

    // Fill with 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h10 + 8'(i);
      tick();
      chk("fill_count", data_count, i + 1);
      chk("fill_af", almost_full, (i + 1) >= 7);
      chk("fill_full", full, (i + 1) == 8);
      chk("fill_ae", almost_empty, (i + 1) <= 1);
    end

    // Write while full
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", data_count, 8);
    chk("ovf_full", full, 1);

    // Drain in order; 0xAA must never appear
    for (int i = 0; i < 8; i++) begin
      do_read("drain_data", 8'h10 + 8'(i));
      chk("drain_count", data_count, 7 - i);
    end
    chk("drain_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Read while empty
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_set", underflow, 1);
    chk("udf_count", data_count, 0);
`ifndef FIFO_SYNC_PROG_FWFT_EN
    chk("udf_rdata_hold", rd_data, 8'h17);
`endif
    // New error coinciding with clr_err keeps the flag
    rd_en = 1'b1;
    clr_err = 1'b1;
    tick();
    rd_en = 1'b0;
    clr_err = 1'b0;
    chk("udf_set_wins", underflow, 1);

    // Simultaneous write+read on empty: write only
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h33;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("wr_rd_empty_count", data_count, 1);
    chk("wr_rd_empty_udf", underflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("udf_clr", underflow, 0);
    do_read("after_udf_data", 8'h33);
    chk("after_udf_empty", empty, 1);

    // Fill to 4 then steady simultaneous traffic across the wrap
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h40 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("mid_count", data_count, 4);
    chk("mid_af", almost_full, 0);
    chk("mid_ae", almost_empty, 0);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h44 + 8'(i);
      do_read("stream_data", 8'h40 + 8'(i));
      wr_en = 1'b0;
      chk("stream_count", data_count, 4);
    end
    chk("stream_ovf", overflow, 0);
    chk("stream_udf", underflow, 0);

    // Grow to 5, start a read, then reset with traffic on the inputs
    wr_en = 1'b1;
    wr_data = 8'h58;
    tick();
    wr_en = 1'b0;
    chk("pre_rst_count", data_count, 5);
    rd_en = 1'b1;
    tick();
    rst = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_count", data_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_udf", underflow, 0);
`ifndef FIFO_SYNC_PROG_FWFT_EN
    chk("mid_rst_rdata", rd_data, 0);
`endif
    wr_en = 1'b1;
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    do_read("post_rst_data", 8'h99);
    chk("post_rst_empty", empty, 1);

`ifdef FIFO_SYNC_PROG_FWFT_EN
    // Fall-through visibility without rd_en
    wr_en = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    chk("fwft_data", rd_data, 8'h5A);
    chk("fwft_not_empty", empty, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fwft_pop_empty", empty, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
